// File: rtl/note_draw_scheduler_if.sv
// Note scheduler bus: event enqueue side, drawer handshake and drawer operands.
// Latency: none, wires only.
// Backpressure: note_ready gates enqueue; draw_done closes each draw started by ld_note.
interface note_draw_scheduler_if;
    logic [3:0] note_in;
    logic [1:0] octave_in;
    logic       note_valid;
    logic       note_ready;
    logic       draw_done;
    logic [3:0] note;
    logic [1:0] octave;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       ld_note;
    logic       overflow;
    logic       timeout_err;

    // Event source and note drawer side
    modport master (
        output note_in, octave_in, note_valid, draw_done,
        input  note_ready, note, octave, x, y, colour, ld_note, overflow, timeout_err
    );

    // Scheduler side
    modport slave (
        input  note_in, octave_in, note_valid, draw_done,
        output note_ready, note, octave, x, y, colour, ld_note, overflow, timeout_err
    );
endinterface

// File: rtl/note_draw_scheduler.sv
// Queues note events and hands them one at a time to a note drawer at successive screen slots.
// Latency: event enqueued at edge E0 into an idle, empty queue gives ld_note in the cycle after E2.
// Backpressure: note_ready low when the queue is full (valid pushes then set overflow); optional
// octave-based colour is enabled by defining NOTE_SCHED_OCTAVE_COLOUR_EN, otherwise colour is white.
module note_draw_scheduler #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned NUM_SLOTS  = 4,
    parameter logic [7:0]  X_BASE     = 8'd4,
    parameter logic [7:0]  SLOT_PITCH = 8'd40,
    parameter logic [6:0]  Y_POS      = 7'd54,
    parameter logic [10:0] TIMEOUT    = 11'd1023
) (
    input  logic                clk,
    input  logic                reset,
    note_draw_scheduler_if.slave bus
);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_DONE = 2'd2,
        ADVANCE   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [5:0]      mem_q [FIFO_DEPTH];
    logic [5:0]      mem_d [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            pending_q, pending_d;
    logic [SW-1:0]   slot_q, slot_d;
    logic [10:0]     wait_cnt_q, wait_cnt_d;
    logic [3:0]      note_q, note_d;
    logic [1:0]      octave_q, octave_d;
    logic [7:0]      x_q, x_d;
    logic [6:0]      y_q, y_d;
    logic [2:0]      colour_q, colour_d;
    logic            overflow_q, overflow_d;
    logic            timeout_q, timeout_d;

    logic            code_ok;
    logic            full;
    logic            push;
    logic            pop;
    logic [5:0]      head;
    logic [10:0]     wait_inc;
    logic [2:0]      colour_sel;

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign code_ok = (bus.note_in >= 4'd1) && (bus.note_in <= 4'd12);
    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign push    = bus.note_valid && code_ok && !full;
    assign head    = mem_q[rd_ptr_q];

    // Queue storage, pointers, occupancy and the sticky overflow flag
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        // The FSM sees occupancy one cycle late: a fresh push is never popped in its own
        // cycle, and a pop is always followed by several cycles before IDLE looks again,
        // so pending_q never claims an entry that has already been consumed.
        pending_d  = (count_q != '0);
        if (push) begin
            mem_d[wr_ptr_q] = {bus.octave_in, bus.note_in};
            wr_ptr_d        = ptr_next(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
        if (bus.note_valid && code_ok && full) begin
            overflow_d = 1'b1;
        end
    end

    // Colour chosen for the entry about to be loaded
    always_comb begin
`ifdef NOTE_SCHED_OCTAVE_COLOUR_EN
        case (head[5:4])
            2'd0:    colour_sel = 3'b100;
            2'd1:    colour_sel = 3'b010;
            2'd2:    colour_sel = 3'b001;
            default: colour_sel = 3'b111;
        endcase
`else
        colour_sel = 3'b111;
`endif
    end

    // Draw sequencing: load operands, wait for the drawer (bounded), step to the next slot
    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        note_d     = note_q;
        octave_d   = octave_q;
        x_d        = x_q;
        y_d        = y_q;
        colour_d   = colour_q;
        pop        = 1'b0;
        wait_inc   = wait_cnt_q + 11'd1;
        case (state_q)
            IDLE: begin
                if (pending_q) begin
                    state_d  = LOAD;
                    pop      = 1'b1;
                    note_d   = head[3:0];
                    octave_d = head[5:4];
                    x_d      = X_BASE + 8'(slot_q) * SLOT_PITCH;
                    y_d      = Y_POS;
                    colour_d = colour_sel;
                end
            end
            LOAD: begin
                state_d    = WAIT_DONE;
                wait_cnt_d = '0;
            end
            WAIT_DONE: begin
                // A completed draw takes priority over a timeout landing on the same edge
                if (bus.draw_done) begin
                    state_d = ADVANCE;
                end else begin
                    wait_cnt_d = wait_inc;
                    if (wait_inc == TIMEOUT) begin
                        timeout_d = 1'b1;
                        state_d   = ADVANCE;
                    end
                end
            end
            ADVANCE: begin
                state_d = IDLE;
                slot_d  = (slot_q == SW'(NUM_SLOTS - 1)) ? '0 : slot_q + SW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // Queue registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            pending_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    // Sequencer and operand registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            slot_q     <= '0;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
            note_q     <= '0;
            octave_q   <= '0;
            x_q        <= '0;
            y_q        <= '0;
            colour_q   <= '0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
            note_q     <= note_d;
            octave_q   <= octave_d;
            x_q        <= x_d;
            y_q        <= y_d;
            colour_q   <= colour_d;
        end
    end

    assign bus.note_ready  = !full;
    assign bus.ld_note     = (state_q == LOAD);
    assign bus.note        = note_q;
    assign bus.octave      = octave_q;
    assign bus.x           = x_q;
    assign bus.y           = y_q;
    assign bus.colour      = colour_q;
    assign bus.overflow    = overflow_q;
    assign bus.timeout_err = timeout_q;
endmodule

// File: tb/tb_note_draw_scheduler.sv
// Directed bench for note_draw_scheduler: reset values, single draw latency, overflow,
// slot wrap, timeout, code rejection and reset during a draw.
module tb_note_draw_scheduler;
    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    note_draw_scheduler_if bus ();

    note_draw_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] exp_colour(input logic [1:0] o);
`ifdef NOTE_SCHED_OCTAVE_COLOUR_EN
        case (o)
            2'd0:    return 3'b100;
            2'd1:    return 3'b010;
            2'd2:    return 3'b001;
            default: return 3'b111;
        endcase
`else
        if (o > 2'd3) return 3'b000;
        return 3'b111;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive_ev(input logic [3:0] n, input logic [1:0] o);
        bus.note_valid = 1'b1;
        bus.note_in    = n;
        bus.octave_in  = o;
        tick();
        bus.note_valid = 1'b0;
    endtask

    task automatic pulse_done();
        bus.draw_done = 1'b1;
        tick();
        bus.draw_done = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_ld(input string tag, input int max);
        int i = 0;
        while (bus.ld_note !== 1'b1 && i < max) begin
            tick();
            i++;
        end
        check({tag, " ld_note"}, 32'(bus.ld_note), 32'd1);
    endtask

    task automatic count_ld(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (bus.ld_note === 1'b1) pulses++;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " note"},   32'(bus.note),        32'd0);
        check({tag, " octave"}, 32'(bus.octave),      32'd0);
        check({tag, " x"},      32'(bus.x),           32'd0);
        check({tag, " y"},      32'(bus.y),           32'd0);
        check({tag, " colour"}, 32'(bus.colour),      32'd0);
        check({tag, " ld"},     32'(bus.ld_note),     32'd0);
        check({tag, " ovf"},    32'(bus.overflow),    32'd0);
        check({tag, " tmo"},    32'(bus.timeout_err), 32'd0);
        check({tag, " ready"},  32'(bus.note_ready),  32'd1);
    endtask

    initial begin
        logic [7:0] wrap_x   [5] = '{8'd4, 8'd44, 8'd84, 8'd124, 8'd4};
        logic [3:0] wrap_n   [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd12};
        logic [1:0] wrap_o   [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic       ovf_rdy  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic       ovf_ld   [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic       ovf_flag [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int pulses;

        n_vec = 0;
        n_err = 0;
        clk = 1'b0;
        reset = 1'b0;
        bus.note_in = '0;
        bus.octave_in = '0;
        bus.note_valid = 1'b0;
        bus.draw_done = 1'b0;

        // Reset values, checked before the first clock edge
        #2 reset = 1'b1;
        #1 check_all_zero("rst");
        tick();
        tick();
        reset = 1'b0;

        // Single event: ld_note in the cycle after E2, operands for slot 0
        drive_ev(4'd5, 2'd1);
        check("single ld E0", 32'(bus.ld_note), 32'd0);
        tick();
        check("single ld E1", 32'(bus.ld_note), 32'd0);
        tick();
        check("single ld E2", 32'(bus.ld_note), 32'd1);
        check("single note",  32'(bus.note),    32'd5);
        check("single oct",   32'(bus.octave),  32'd1);
        check("single x",     32'(bus.x),       32'd4);
        check("single y",     32'(bus.y),       32'd54);
        check("single col",   32'(bus.colour),  32'(exp_colour(2'd1)));
        tick();
        check("single ld E3", 32'(bus.ld_note), 32'd0);
        pulse_done();
        tick();
        count_ld(8, pulses);
        check("single no extra ld", 32'(pulses), 32'd0);
        check("single note hold",   32'(bus.note),   32'd5);
        check("single col hold",    32'(bus.colour), 32'(exp_colour(2'd1)));

        // Slot wrap: x steps 4, 44, 84, 124 then back to 4
        apply_reset();
        drive_ev(wrap_n[0], wrap_o[0]);
        tick();
        tick();
        check("wrap0 ld", 32'(bus.ld_note), 32'd1);
        check("wrap0 x",  32'(bus.x),       32'(wrap_x[0]));
        for (int k = 1; k < 5; k++) drive_ev(wrap_n[k], wrap_o[k]);
        repeat (6) tick();
        pulse_done();
        for (int k = 1; k < 5; k++) begin
            wait_ld($sformatf("wrap%0d", k), 20);
            check($sformatf("wrap%0d x", k),    32'(bus.x),      32'(wrap_x[k]));
            check($sformatf("wrap%0d note", k), 32'(bus.note),   32'(wrap_n[k]));
            check($sformatf("wrap%0d oct", k),  32'(bus.octave), 32'(wrap_o[k]));
            check($sformatf("wrap%0d col", k),  32'(bus.colour), 32'(exp_colour(wrap_o[k])));
            repeat (10) tick();
            pulse_done();
        end
        check("wrap ovf",   32'(bus.overflow),    32'd0);
        check("wrap tmo",   32'(bus.timeout_err), 32'd0);
        check("wrap ready", 32'(bus.note_ready),  32'd1);

        // Overflow: six back-to-back events, five accepted, sixth flags overflow
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            bus.note_valid = 1'b1;
            bus.note_in    = 4'(7 + i);
            bus.octave_in  = 2'(i % 4);
            tick();
            check($sformatf("ovf%0d ready", i), 32'(bus.note_ready), 32'(ovf_rdy[i]));
            check($sformatf("ovf%0d ld", i),    32'(bus.ld_note),    32'(ovf_ld[i]));
            check($sformatf("ovf%0d flag", i),  32'(bus.overflow),   32'(ovf_flag[i]));
        end
        bus.note_valid = 1'b0;
        check("ovf draw0 note", 32'(bus.note), 32'd7);
        tick();
        pulse_done();
        for (int k = 1; k < 5; k++) begin
            wait_ld($sformatf("ovf draw%0d", k), 20);
            check($sformatf("ovf draw%0d note", k), 32'(bus.note),   32'(7 + k));
            check($sformatf("ovf draw%0d oct", k),  32'(bus.octave), 32'(k % 4));
            tick();
            pulse_done();
        end
        count_ld(10, pulses);
        check("ovf sixth dropped", 32'(pulses),          32'd0);
        check("ovf drained ready", 32'(bus.note_ready),  32'd1);
        check("ovf sticky",        32'(bus.overflow),    32'd1);
        reset = 1'b1;
        #1 check("ovf cleared by reset", 32'(bus.overflow), 32'd0);
        tick();
        reset = 1'b0;

        // Code rejection and stray draw_done while idle
        apply_reset();
        drive_ev(4'd0, 2'd0);
        drive_ev(4'd13, 2'd1);
        pulse_done();
        tick();
        pulse_done();
        count_ld(10, pulses);
        check("rej no ld",  32'(pulses),          32'd0);
        check("rej ovf",    32'(bus.overflow),    32'd0);
        check("rej tmo",    32'(bus.timeout_err), 32'd0);
        check("rej ready",  32'(bus.note_ready),  32'd1);
        check("rej note",   32'(bus.note),        32'd0);
        drive_ev(4'd9, 2'd2);
        tick();
        tick();
        check("rej next ld",   32'(bus.ld_note), 32'd1);
        check("rej next note", 32'(bus.note),    32'd9);
        check("rej next x",    32'(bus.x),       32'd4);
        tick();
        pulse_done();

        // Timeout: error exactly TIMEOUT cycles after WAIT_DONE entry, then slot 1
        apply_reset();
        drive_ev(4'd3, 2'd2);
        tick();
        tick();
        check("tmo ld", 32'(bus.ld_note), 32'd1);
        tick();
        repeat (1022) tick();
        check("tmo before", 32'(bus.timeout_err), 32'd0);
        tick();
        check("tmo at limit", 32'(bus.timeout_err), 32'd1);
        check("tmo no ld",    32'(bus.ld_note),     32'd0);
        drive_ev(4'd6, 2'd0);
        tick();
        check("tmo next ld E1", 32'(bus.ld_note), 32'd0);
        tick();
        check("tmo next ld E2", 32'(bus.ld_note),     32'd1);
        check("tmo next x",     32'(bus.x),           32'd44);
        check("tmo next note",  32'(bus.note),        32'd6);
        check("tmo sticky",     32'(bus.timeout_err), 32'd1);
        reset = 1'b1;
        #1 check("tmo cleared by reset", 32'(bus.timeout_err), 32'd0);
        tick();
        reset = 1'b0;

        // Reset during WAIT_DONE with two entries still queued
        tick();
        drive_ev(4'd10, 2'd3);
        drive_ev(4'd11, 2'd2);
        drive_ev(4'd12, 2'd1);
        check("mid ld", 32'(bus.ld_note), 32'd1);
        tick();
        tick();
        check("mid note before", 32'(bus.note), 32'd10);
        check("mid ready before", 32'(bus.note_ready), 32'd1);
        reset = 1'b1;
        #1 check_all_zero("mid rst");
        tick();
        tick();
        reset = 1'b0;
        count_ld(20, pulses);
        check("mid no ld after", 32'(pulses), 32'd0);
        drive_ev(4'd2, 2'd1);
        tick();
        tick();
        check("mid new ld",   32'(bus.ld_note), 32'd1);
        check("mid new note", 32'(bus.note),    32'd2);
        check("mid new x",    32'(bus.x),       32'd4);
        tick();
        pulse_done();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/note_draw_scheduler.md
NOTE_DRAW_SCHEDULER -- requirements
Module: note_draw_scheduler

Interface
REQ-001 Parameters SHALL be (name, default, meaning): FIFO_DEPTH, 4, note event queue depth (power of two).
REQ-002 NUM_SLOTS, 4, number of on-screen note positions.
REQ-003 X_BASE, 8'd4, x of slot 0; SLOT_PITCH, 8'd40, x step per slot; Y_POS, 7'd54, fixed y of every slot.
REQ-004 TIMEOUT, 11'd1023, maximum cycles to wait for draw_done.
REQ-005 Ports SHALL be (name, direction, width, meaning): clk, in, 1, the only clock.
REQ-006 reset, in, 1, asynchronous active-high reset.
REQ-007 note_in, in, 4, note code; 1..12 valid, anything else is rejected.
REQ-008 octave_in, in, 2, octave code.
REQ-009 note_valid, in, 1, one-cycle request to enqueue note_in/octave_in.
REQ-010 note_ready, out, 1, high when the FIFO is not full.
REQ-011 draw_done, in, 1, one-cycle pulse from the note drawer when a draw finishes.
REQ-012 note, out, 4; octave, out, 2; x, out, 8; y, out, 7; colour, out, 3: drawer operands.
REQ-013 ld_note, out, 1, one-cycle draw start pulse.
REQ-014 overflow, out, 1; timeout_err, out, 1: sticky error flags.

Function
REQ-015 An event SHALL be enqueued at a clock edge only if note_valid=1, note_ready=1 and note_in is in 1..12.
- Invalid codes SHALL be dropped silently with no flag.
REQ-016 A valid event with note_valid=1 while full SHALL be dropped and SHALL set overflow.
REQ-017 There is no bypass path. Enqueue into an empty FIFO and a same-cycle pop SHALL never coincide.
- When the FIFO is full, a pop and a push in the same cycle SHALL drop the push, because note_ready was low.
REQ-018 The FSM SHALL have states IDLE, LOAD, WAIT_DONE, ADVANCE.
- IDLE goes to LOAD when the FIFO is non-empty.
- LOAD goes to WAIT_DONE unconditionally.
- WAIT_DONE goes to ADVANCE on draw_done or when the wait counter reaches TIMEOUT.
- ADVANCE goes to IDLE.
REQ-019 On entry to LOAD the head entry SHALL be popped and note/octave registered.
- x SHALL be registered as X_BASE + slot*SLOT_PITCH (8-bit, wrapping), and y as Y_POS.
- ld_note SHALL be high exactly during the LOAD cycle.
REQ-020 The note, octave, x, y and colour outputs SHALL hold their values from LOAD until the next LOAD.
REQ-021 Latency: for an event sampled at edge E0 with IDLE and an empty FIFO, ld_note SHALL be high in the cycle following edge E2.
REQ-022 The wait counter SHALL clear on entering WAIT_DONE and increment each WAIT_DONE cycle.
- Reaching TIMEOUT SHALL set timeout_err and force ADVANCE.
REQ-023 draw_done SHALL be ignored in every state except WAIT_DONE.
REQ-024 ADVANCE SHALL increment slot modulo NUM_SLOTS (NUM_SLOTS-1 wraps to 0).
REQ-025 overflow and timeout_err SHALL be cleared only by reset.

Reset
REQ-026 Asserting reset at any time, including mid-draw, SHALL immediately:
- set the FSM to IDLE;
- empty the FIFO;
- set slot to 0;
- set note, octave, x, y, colour, ld_note, overflow and timeout_err to 0;
- set note_ready to 1.
REQ-027 After reset deasserts, no ld_note SHALL occur until a new event is enqueued.

Configuration
REQ-028 With macro NOTE_SCHED_OCTAVE_COLOUR_EN defined, colour SHALL be latched in LOAD from the octave: 0→3'b100, 1→3'b010, 2→3'b001, 3→3'b111.
REQ-029 Without NOTE_SCHED_OCTAVE_COLOUR_EN, colour SHALL be latched as 3'b111 in every LOAD.

Verification
REQ-030 Single event: reset, then note_in=4'd5, octave_in=2'd1, one pulse.
- Expect ld_note one cycle at E2 with note=5, octave=1, x=4, y=54.
- Expect colour=3'b010 with the macro defined, 3'b111 without.
REQ-031 Overflow: six back-to-back valid events with draw_done held low.
- Expect a 1-cycle pop after E2, so 5 events are accepted.
- Expect note_ready to drop when 4 entries are pending and overflow=1 from the sixth; drawn order matches the accepted order.
REQ-032 Slot wrap: five events, with draw_done pulsed 10 cycles after each ld_note.
- Expect x sequence 4, 44, 84, 124, 4.
REQ-033 Timeout: one event, draw_done never pulsed.
- Expect timeout_err=1 exactly TIMEOUT cycles after WAIT_DONE entry, then slot=1 and IDLE.
REQ-034 Rejection: note_in=0 and note_in=13 with note_valid.
- Expect no ld_note and no flags.
- Expect draw_done pulses in IDLE to have no effect.
REQ-035 Reset mid-draw: reset asserted during WAIT_DONE with 2 entries queued.
- Expect all outputs 0 immediately and no ld_note afterwards until a new event is enqueued.
